// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard
//   Control-side pipeline for the 5-stage MIPS core. It takes the decoded
//   WB/MEM/EX control buses and register numbers of the instruction in ID and
//   carries them through the ID/EX, EX/MEM and MEM/WB stage registers. It also
//   detects load-use hazards, squashes instructions on a taken branch, and
//   generates the EX-stage forwarding selects.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset, clears every stage register
//   i_enable       global advance enable; 0 freezes every register
//   i_flush        branch taken in MEM; squashes the ID and EX instructions
//   i_ctrl_wb_bus  WB controls of ID instr   [1]=RegWrite [0]=MemtoReg
//   i_ctrl_mem_bus MEM controls of ID instr  [2]=MemRead [1]=MemWrite [0]=Branch
//   i_ctrl_exc_bus EX controls of ID instr (opaque)
//   i_id_rs/rt     source registers of ID instr
//   i_id_wreg      destination register of ID instr
//   o_ex_ctrl_exc  EX controls in EX stage
//   o_mem_ctrl_mem MEM controls in MEM stage
//   o_wb_ctrl_wb   WB controls in WB stage
//   o_wb_wreg      destination register in WB stage
//   o_stall        hold PC and IF/ID; a bubble enters EX on this edge
//   o_fwd_a/b      EX operand forward select: 10=from MEM, 01=from WB, 00=none
module ctrl_pipe_hazard #(
  parameter int NB_CTRL_EX = 7,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_REG     = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
  input  logic [NB_REG-1:0]     i_id_rs,
  input  logic [NB_REG-1:0]     i_id_rt,
  input  logic [NB_REG-1:0]     i_id_wreg,
  output logic [NB_CTRL_EX-1:0] o_ex_ctrl_exc,
  output logic [NB_CTRL_M-1:0]  o_mem_ctrl_mem,
  output logic [NB_CTRL_WB-1:0] o_wb_ctrl_wb,
  output logic [NB_REG-1:0]     o_wb_wreg,
  output logic                  o_stall,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b
);

  logic [NB_CTRL_WB-1:0] ex_wb;
  logic [NB_CTRL_M-1:0]  ex_m;
  logic [NB_CTRL_EX-1:0] ex_ex;
  logic [NB_REG-1:0]     ex_rs;
  logic [NB_REG-1:0]     ex_rt;
  logic [NB_REG-1:0]     ex_wreg;

  logic [NB_CTRL_WB-1:0] mem_wb;
  logic [NB_CTRL_M-1:0]  mem_m;
  logic [NB_REG-1:0]     mem_wreg;

  logic [NB_CTRL_WB-1:0] wb_wb;
  logic [NB_REG-1:0]     wb_wreg;

  logic ex_is_load;
  logic ex_hits_id;

  // A load in EX whose destination is read by the instruction in ID cannot be
  // forwarded in time; hold ID for one cycle. A flush or a frozen pipe makes
  // the hazard moot.
  assign ex_is_load = ex_m[2] & (ex_wreg != '0);
  assign ex_hits_id = (ex_wreg == i_id_rs) | (ex_wreg == i_id_rt);
  assign o_stall    = ex_is_load & ex_hits_id & ~i_flush & i_enable;

  function automatic logic [1:0] fwd_sel(input logic [NB_REG-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    // MEM holds the more recent write, so it is checked first.
    if (mem_wb[1] && (mem_wreg != '0) && (mem_wreg == src))
      sel = 2'b10;
    else if (wb_wb[1] && (wb_wreg != '0) && (wb_wreg == src))
      sel = 2'b01;
    return sel;
  endfunction

  assign o_fwd_a = fwd_sel(ex_rs);
  assign o_fwd_b = fwd_sel(ex_rt);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_wb    <= '0;
      ex_m     <= '0;
      ex_ex    <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_wreg  <= '0;
      mem_wb   <= '0;
      mem_m    <= '0;
      mem_wreg <= '0;
      wb_wb    <= '0;
      wb_wreg  <= '0;
    end else if (i_enable) begin
      // WB always takes MEM, so a branch sitting in MEM still completes.
      wb_wb   <= mem_wb;
      wb_wreg <= mem_wreg;

      if (i_flush) begin
        mem_wb   <= '0;
        mem_m    <= '0;
        mem_wreg <= '0;
      end else begin
        mem_wb   <= ex_wb;
        mem_m    <= ex_m;
        mem_wreg <= ex_wreg;
      end

      if (i_flush || o_stall) begin
        ex_wb   <= '0;
        ex_m    <= '0;
        ex_ex   <= '0;
        ex_rs   <= '0;
        ex_rt   <= '0;
        ex_wreg <= '0;
      end else begin
        ex_wb   <= i_ctrl_wb_bus;
        ex_m    <= i_ctrl_mem_bus;
        ex_ex   <= i_ctrl_exc_bus;
        ex_rs   <= i_id_rs;
        ex_rt   <= i_id_rt;
        ex_wreg <= i_id_wreg;
      end
    end
  end

  assign o_ex_ctrl_exc  = ex_ex;
  assign o_mem_ctrl_mem = mem_m;
  assign o_wb_ctrl_wb   = wb_wb;
  assign o_wb_wreg      = wb_wreg;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
module tb_ctrl_pipe_hazard;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [6:0] ex;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
  } instr_t;

  localparam instr_t NOP = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic flush = 1'b0;
  instr_t id = '0;

  logic [6:0] o_ex_ctrl_exc;
  logic [2:0] o_mem_ctrl_mem;
  logic [1:0] o_wb_ctrl_wb;
  logic [4:0] o_wb_wreg;
  logic       o_stall;
  logic [1:0] o_fwd_a;
  logic [1:0] o_fwd_b;

  int n_checks = 0;
  int n_errors = 0;
  logic check_en = 1'b0;

  // instructions currently occupying each stage, as the bench believes them
  instr_t s_ex = '0;
  instr_t s_mem = '0;
  instr_t s_wb = '0;

  always #5 clk = ~clk;

  ctrl_pipe_hazard dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (en),
    .i_flush        (flush),
    .i_ctrl_wb_bus  (id.wb),
    .i_ctrl_mem_bus (id.m),
    .i_ctrl_exc_bus (id.ex),
    .i_id_rs        (id.rs),
    .i_id_rt        (id.rt),
    .i_id_wreg      (id.wreg),
    .o_ex_ctrl_exc  (o_ex_ctrl_exc),
    .o_mem_ctrl_mem (o_mem_ctrl_mem),
    .o_wb_ctrl_wb   (o_wb_ctrl_wb),
    .o_wb_wreg      (o_wb_wreg),
    .o_stall        (o_stall),
    .o_fwd_a        (o_fwd_a),
    .o_fwd_b        (o_fwd_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A reader must wait if the instruction right ahead of it is a load of one
  // of its sources (register 0 is never a real dependency).
  function automatic logic want_stall();
    return en && !flush && s_ex.m[2] && (s_ex.wreg != 0) &&
           ((s_ex.wreg == id.rs) || (s_ex.wreg == id.rt));
  endfunction

  // The newest older writer of src provides the value.
  function automatic logic [1:0] want_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (s_mem.wb[1] && s_mem.wreg == src) return 2'b10;
    if (s_wb.wb[1] && s_wb.wreg == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_ex_ctrl",  32'(o_ex_ctrl_exc),  32'(s_ex.ex));
      chk("cyc_mem_ctrl", 32'(o_mem_ctrl_mem), 32'(s_mem.m));
      chk("cyc_wb_ctrl",  32'(o_wb_ctrl_wb),   32'(s_wb.wb));
      chk("cyc_wb_wreg",  32'(o_wb_wreg),      32'(s_wb.wreg));
      chk("cyc_stall",    32'(o_stall),        32'(want_stall()));
      chk("cyc_fwd_a",    32'(o_fwd_a),        32'(want_fwd(s_ex.rs)));
      chk("cyc_fwd_b",    32'(o_fwd_b),        32'(want_fwd(s_ex.rt)));
    end
  end

  task automatic tick();
    logic hold;
    @(posedge clk);
    if (rst) begin
      s_ex = '0; s_mem = '0; s_wb = '0;
    end else if (en) begin
      hold  = want_stall();
      s_wb  = s_mem;
      s_mem = flush ? NOP : s_ex;
      s_ex  = (flush || hold) ? NOP : id;
    end
    #1;
  endtask

  function automatic instr_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [6:0] ex,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wreg);
    instr_t t;
    t.wb = wb; t.m = m; t.ex = ex; t.rs = rs; t.rt = rt; t.wreg = wreg;
    return t;
  endfunction

  initial begin
    // 1. reset and plain advance
    id = mk(2'b11, 3'b111, 7'h7f, 5'd3, 5'd4, 5'd5);
    tick();
    check_en = 1'b1;
    tick();
    chk("rst_ex_ctrl", 32'(o_ex_ctrl_exc), 32'h0);
    chk("rst_wb_ctrl", 32'(o_wb_ctrl_wb), 32'h0);
    chk("rst_stall", 32'(o_stall), 32'h0);
    chk("rst_fwd", 32'({o_fwd_a, o_fwd_b}), 32'h0);
    rst = 1'b0;
    id = mk(2'b10, 3'b000, 7'h55, 5'd1, 5'd2, 5'd3);
    tick();
    chk("adv_ex_ctrl", 32'(o_ex_ctrl_exc), 32'h55);
    id = NOP;
    tick();
    tick();
    chk("adv_wb_ctrl", 32'(o_wb_ctrl_wb), 32'h2);
    chk("adv_wb_wreg", 32'(o_wb_wreg), 32'd3);

    // 2. load-use: one stall, bubble, then WB forward
    id = mk(2'b11, 3'b100, 7'h01, 5'd1, 5'd8, 5'd8);
    tick();
    id = mk(2'b10, 3'b000, 7'h22, 5'd8, 5'd9, 5'd10);
    #1;
    chk("lu_stall_on", 32'(o_stall), 32'h1);
    tick();
    #1;
    chk("lu_bubble_ex", 32'(o_ex_ctrl_exc), 32'h0);
    chk("lu_stall_off", 32'(o_stall), 32'h0);
    chk("lu_load_mem", 32'(o_mem_ctrl_mem), 32'h4);
    tick();
    id = NOP;
    chk("lu_bubble_mem", 32'(o_mem_ctrl_mem), 32'h0);
    chk("lu_add_ex", 32'(o_ex_ctrl_exc), 32'h22);
    chk("lu_fwd_a", 32'(o_fwd_a), 32'h1);
    tick();

    // 3. two writers of r5: MEM wins
    id = mk(2'b10, 3'b000, 7'h11, 5'd1, 5'd2, 5'd5);
    tick();
    id = mk(2'b10, 3'b000, 7'h12, 5'd1, 5'd2, 5'd5);
    tick();
    id = mk(2'b10, 3'b000, 7'h13, 5'd5, 5'd5, 5'd6);
    tick();
    id = NOP;
    chk("pri_fwd_a", 32'(o_fwd_a), 32'h2);
    chk("pri_fwd_b", 32'(o_fwd_b), 32'h2);
    tick();

    // 4. register 0 never matches
    id = mk(2'b10, 3'b000, 7'h14, 5'd1, 5'd2, 5'd0);
    tick();
    id = mk(2'b10, 3'b000, 7'h15, 5'd0, 5'd0, 5'd7);
    tick();
    id = NOP;
    chk("r0_fwd_a", 32'(o_fwd_a), 32'h0);
    id = mk(2'b11, 3'b100, 7'h16, 5'd1, 5'd2, 5'd0);
    tick();
    id = mk(2'b10, 3'b000, 7'h17, 5'd0, 5'd0, 5'd7);
    #1;
    chk("r0_stall", 32'(o_stall), 32'h0);
    tick();
    id = NOP;
    tick();
    tick();

    // 5. flush beats a load-use hazard
    id = mk(2'b10, 3'b000, 7'h31, 5'd1, 5'd2, 5'd12);
    tick();
    id = mk(2'b11, 3'b100, 7'h32, 5'd1, 5'd2, 5'd9);
    tick();
    id = mk(2'b10, 3'b000, 7'h33, 5'd9, 5'd0, 5'd13);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(o_stall), 32'h0);
    tick();
    flush = 1'b0;
    id = NOP;
    chk("fl_ex", 32'(o_ex_ctrl_exc), 32'h0);
    chk("fl_mem", 32'(o_mem_ctrl_mem), 32'h0);
    chk("fl_wb_ctrl", 32'(o_wb_ctrl_wb), 32'h2);
    chk("fl_wb_wreg", 32'(o_wb_wreg), 32'd12);
    tick();
    tick();

    // 6. freeze for 3 cycles with a hazard pending, then resume
    id = mk(2'b10, 3'b000, 7'h41, 5'd3, 5'd4, 5'd1);
    tick();
    id = mk(2'b11, 3'b100, 7'h42, 5'd3, 5'd4, 5'd2);
    tick();
    id = mk(2'b10, 3'b000, 7'h43, 5'd2, 5'd4, 5'd3);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("frz_stall", 32'(o_stall), 32'h0);
      chk("frz_ex", 32'(o_ex_ctrl_exc), 32'h42);
      chk("frz_mem", 32'(o_mem_ctrl_mem), 32'h0);
      tick();
    end
    en = 1'b1;
    #1;
    chk("res_stall", 32'(o_stall), 32'h1);
    tick();
    chk("res_wb_wreg", 32'(o_wb_wreg), 32'd1);
    chk("res_mem", 32'(o_mem_ctrl_mem), 32'h4);
    tick();
    id = NOP;
    chk("res_ex", 32'(o_ex_ctrl_exc), 32'h43);
    chk("res_fwd_a", 32'(o_fwd_a), 32'h1);
    tick();

    // mid-stream reset discards everything in flight
    id = mk(2'b10, 3'b010, 7'h51, 5'd1, 5'd2, 5'd4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    id = NOP;
    chk("mrst_ex", 32'(o_ex_ctrl_exc), 32'h0);
    chk("mrst_mem", 32'(o_mem_ctrl_mem), 32'h0);
    chk("mrst_wb", 32'({o_wb_ctrl_wb, o_wb_wreg}), 32'h0);
    tick();
    tick();
    tick();

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Receiving end of the control-bus interface driven by the decoder: consumes the per-instruction WB/MEM/EX control buses and register numbers in ID.
- Carries them through the ID/EX, EX/MEM and MEM/WB stage registers.
- Detects load-use hazards and inserts bubbles, squashes on a taken branch, and generates forwarding selects for the EX stage.
- Sits between the control unit and the datapath stage registers of the 5-stage MIPS pipeline.

Parameters:
NB_CTRL_EX, 7, width of EX control bus (opaque, carried unchanged)
NB_CTRL_M, 3, width of MEM control bus: [2]=MemRead, [1]=MemWrite, [0]=Branch
NB_CTRL_WB, 2, width of WB control bus: [1]=RegWrite, [0]=MemtoReg
NB_REG, 5, register-number width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous, active-high reset
i_enable  in  1  global advance enable; 0 freezes every register
i_flush  in  1  branch taken in MEM; squash instructions in ID and EX
i_ctrl_wb_bus  in  NB_CTRL_WB  WB controls of instruction in ID
i_ctrl_mem_bus  in  NB_CTRL_M  MEM controls of instruction in ID
i_ctrl_exc_bus  in  NB_CTRL_EX  EX controls of instruction in ID
i_id_rs  in  NB_REG  rs of instruction in ID
i_id_rt  in  NB_REG  rt of instruction in ID
i_id_wreg  in  NB_REG  destination register (already muxed rd/rt/31)
o_ex_ctrl_exc  out  NB_CTRL_EX  EX controls in EX stage
o_mem_ctrl_mem  out  NB_CTRL_M  MEM controls in MEM stage
o_wb_ctrl_wb  out  NB_CTRL_WB  WB controls in WB stage
o_wb_wreg  out  NB_REG  destination register in WB stage
o_stall  out  1  hold PC and IF/ID; bubble inserted into EX
o_fwd_a  out  2  forward select for EX operand rs
o_fwd_b  out  2  forward select for EX operand rt

Behaviour:
Internal stage registers:
- EX: ex_wb, ex_m, ex_ex, ex_rs, ex_rt, ex_wreg
- MEM: mem_wb, mem_m, mem_wreg
- WB: wb_wb, wb_wreg

Reset:
- i_rst=1 at a rising edge clears all stage registers to 0.
- All outputs read 0 the cycle after the reset edge: o_stall=0, o_fwd_a=o_fwd_b=2'b00.
- Reset mid-stream discards every in-flight instruction.

Edge priority: reset > !i_enable (hold all) > flush > stall > normal advance.

Normal advance (1 cycle per stage):
- EX <= ID inputs; MEM <= EX; WB <= MEM.
- Total latency from ID bus to o_wb_ctrl_wb is 3 cycles.

Stall (load-use hazard):
- o_stall = ex_m[2] & (ex_wreg != 0) & (ex_wreg == i_id_rs | ex_wreg == i_id_rt) & !i_flush & i_enable. Combinational.
- On a stall edge, the EX stage loads a bubble: all EX-stage fields are 0. MEM and WB advance normally.
- The ID inputs are re-presented by the upstream hold next cycle. The stall clears by itself after exactly 1 cycle, because the load has then moved to MEM.

Flush:
- On a flush edge, EX and MEM load bubbles (all fields 0). WB advances from MEM, so the branch itself completes.
- A flush coinciding with a hazard does not stall; the flush wins.

Enable:
- i_enable=0 holds all registers unchanged and forces o_stall=0.
- Forwarding outputs stay valid, computed from the held registers.

Forwarding (combinational from stage registers, EX-stage rs; rt is identical using ex_rt):
- 2'b10 if mem_wb[1] & mem_wreg != 0 & mem_wreg == ex_rs
- else 2'b01 if wb_wb[1] & wb_wreg != 0 & wb_wreg == ex_rs
- else 2'b00
- MEM beats WB when both match (most recent value).

Other rules:
- Register 0 never matches for either hazard detection or forwarding.
- A bubble has RegWrite=0, MemRead=0 and MemWrite=0, so it cannot trigger a hazard, forwarding or a memory access.
- No arithmetic is performed; all comparisons are NB_REG-bit equality.

Test Plan:
1. Reset/advance: hold i_rst=1 for 2 edges with non-zero inputs -> all outputs 0. Release, then present wb=2'b10, mem=3'b000, exc=7'h55 for 1 cycle -> o_ex_ctrl_exc=7'h55 at +1 edge, o_wb_ctrl_wb=2'b10 at +3 edges.
2. Load-use: LW with mem=3'b100, wb=2'b11, wreg=8, then ADD with rs=8 in ID -> o_stall=1 for exactly 1 cycle; EX is a bubble (o_ex_ctrl_exc=0) and o_mem_ctrl_mem is 0 one edge later. After re-presenting the ADD, o_fwd_a=2'b01 when it reaches EX.
3. Forwarding priority: ADD wreg=5, then ADD wreg=5, then SUB rs=5, rt=5 -> when SUB is in EX, o_fwd_a=o_fwd_b=2'b10.
4. Register 0: instruction writing wreg=0 followed by a reader with rs=0 -> o_fwd_a=2'b00. A load with wreg=0 followed by a reader with rs=0 -> o_stall=0.
5. Flush + hazard: load in EX with a matching reader in ID, and i_flush=1 the same cycle -> o_stall=0; EX and MEM are 0 after the edge; WB receives the prior MEM contents.
6. Enable freeze: i_enable=0 for 3 cycles mid-stream -> all stage outputs are constant and o_stall=0. Resuming with i_enable=1 continues the sequence with no loss or duplication.
